// File: rtl/sqrt_mult_pkg.sv
// Shared widths, feeder FSM encoding and watchdog default for the sqrt_mult feeder slice.
package sqrt_mult_pkg;
   localparam int OP_W            = 8;
   localparam int RES_W           = 16;
   localparam int DEFAULT_TIMEOUT = 255;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } feeder_state_e;

   typedef struct packed {
      logic [OP_W-1:0] a;
      logic [OP_W-1:0] b;
   } operands_t;
endpackage

// File: rtl/sqrt_mult_fifo.sv
// Small synchronous FIFO; the head is presented combinationally and reads as 0 when empty.
module sqrt_mult_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic [WIDTH-1:0]       din_i,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic [WIDTH-1:0]       head_o
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (do_pop && !do_push) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

   assign count_o = count_q;
   assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
endmodule

// File: rtl/sqrt_mult_feeder.sv
// Feeds queued (a,b) jobs to sqrt_mult_system one at a time and holds each result until drained.
// Operands come straight from the FIFO head, so the pop is deferred to the done cycle.
module sqrt_mult_feeder
   import sqrt_mult_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        in_valid_i,
   output logic                        in_ready_o,
   input  logic [OP_W-1:0]             in_a_i,
   input  logic [OP_W-1:0]             in_b_i,
   output logic                        sys_start_o,
   output logic [OP_W-1:0]             sys_a_o,
   output logic [OP_W-1:0]             sys_b_o,
   input  logic [RES_W-1:0]            sys_result_i,
   input  logic                        sys_done_i,
   output logic                        out_valid_o,
   input  logic                        out_ready_i,
   output logic [RES_W-1:0]            out_result_o,
   output logic [$clog2(FIFO_DEPTH):0] pending_o,
   output logic                        err_o
);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   feeder_state_e    state_q, state_d;
   operands_t        din, head;
   logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic             capture, drain, can_issue;
   logic             out_valid_q, out_valid_d;
   logic [RES_W-1:0] out_result_q, out_result_d;
   logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
   logic             err_q, err_d;

   // Ready is held low while reset is asserted so nothing is pushed into a clearing FIFO.
   assign in_ready_o = !fifo_full && !rst_i;
   assign fifo_push  = in_valid_i && in_ready_o;
   assign din        = {in_a_i, in_b_i};
   assign capture    = (state_q == ST_WAIT) && sys_done_i;
   assign fifo_pop   = capture;
   assign drain      = out_valid_q && out_ready_i;
   assign can_issue  = !fifo_empty && (!out_valid_q || out_ready_i);

   sqrt_mult_fifo #(
      .WIDTH ($bits(operands_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .din_i   (din),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (pending_o),
      .head_o  (head)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (can_issue) state_d = ST_ISSUE;
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT:  if (sys_done_i) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      sys_start_o = (state_q == ST_ISSUE);
      sys_a_o     = head.a;
      sys_b_o     = head.b;
   end

   always_comb begin
      out_valid_d  = out_valid_q;
      out_result_d = out_result_q;
      if (drain) out_valid_d = 1'b0;
      if (capture) begin
         out_valid_d  = 1'b1;
         out_result_d = sys_result_i;
      end
      // Counter restarts as ISSUE hands over to WAIT and saturates at the budget.
      wd_cnt_d = wd_cnt_q;
      if (state_q == ST_ISSUE)
         wd_cnt_d = '0;
      else if (state_q == ST_WAIT && wd_cnt_q != CNT_W'(TIMEOUT_CYCLES))
         wd_cnt_d = wd_cnt_q + 1'b1;
      err_d = err_q || (state_q == ST_WAIT && wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         wd_cnt_q     <= '0;
         err_q        <= 1'b0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_result_q <= out_result_d;
         wd_cnt_q     <= wd_cnt_d;
         err_q        <= err_d;
      end
   end

   assign out_valid_o  = out_valid_q;
   assign out_result_o = out_result_q;
   assign err_o        = err_q;
endmodule

// File: tb/tb_sqrt_mult_feeder.sv
// Bench for sqrt_mult_feeder with a behavioural sqrt_mult_system whose done can be withheld.
module tb_sqrt_mult_feeder;
   localparam int TIMEOUT = 255;
   localparam int LAT     = 5;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        in_valid_i = 1'b0;
   logic        in_ready_o;
   logic [7:0]  in_a_i = '0;
   logic [7:0]  in_b_i = '0;
   logic        sys_start_o;
   logic [7:0]  sys_a_o, sys_b_o;
   logic [15:0] sys_result_i;
   logic        sys_done_i;
   logic        out_valid_o;
   logic        out_ready_i = 1'b0;
   logic [15:0] out_result_o;
   logic [2:0]  pending_o;
   logic        err_o;

   sqrt_mult_feeder #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .in_valid_i   (in_valid_i),
      .in_ready_o   (in_ready_o),
      .in_a_i       (in_a_i),
      .in_b_i       (in_b_i),
      .sys_start_o  (sys_start_o),
      .sys_a_o      (sys_a_o),
      .sys_b_o      (sys_b_o),
      .sys_result_i (sys_result_i),
      .sys_done_i   (sys_done_i),
      .out_valid_o  (out_valid_o),
      .out_ready_i  (out_ready_i),
      .out_result_o (out_result_o),
      .pending_o    (pending_o),
      .err_o        (err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] exp;
   } vec_t;
   vec_t vec [12];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
   endtask

   function automatic int isqrt(input int b);
      int r = 0;
      while ((r + 1) * (r + 1) <= b) r++;
      return r;
   endfunction

   // Behavioural system: samples b at start, a two cycles later, done after LAT unless stalled.
   logic       stall = 1'b0;
   logic       busy;
   int         mcnt;
   logic [7:0] m_a, m_b;
   always @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         busy <= 1'b0; mcnt <= 0; m_a <= '0; m_b <= '0;
         sys_done_i <= 1'b0; sys_result_i <= '0;
      end else begin
         sys_done_i <= 1'b0;
         if (!busy) begin
            if (sys_start_o) begin busy <= 1'b1; mcnt <= 0; m_b <= sys_b_o; end
         end else begin
            mcnt <= mcnt + 1;
            if (mcnt == 2) m_a <= sys_a_o;
            if (mcnt >= LAT && !stall) begin
               busy <= 1'b0;
               sys_done_i <= 1'b1;
               sys_result_i <= 16'(m_a) * 16'(isqrt(int'(m_b)));
            end
         end
      end
   end

   // Protocol monitor sampled on the falling edge.
   int          cyc = 0, start_cnt = 0, done_cnt = 0, last_done = -100;
   int          spacing_err = 0, stab_err = 0;
   logic        job_act = 1'b0;
   logic [7:0]  lock_a = '0, lock_b = '0;
   logic [15:0] got_q [$];
   always @(negedge clk_i) begin
      cyc++;
      if (rst_i) job_act = 1'b0;
      else begin
         if (job_act) begin
            if (sys_a_o !== lock_a || sys_b_o !== lock_b) stab_err++;
            if (sys_done_i) job_act = 1'b0;
         end
         if (sys_start_o) begin
            start_cnt++;
            if (cyc - last_done < 2) spacing_err++;
            job_act = 1'b1; lock_a = sys_a_o; lock_b = sys_b_o;
         end
         if (sys_done_i) begin done_cnt++; last_done = cyc; end
         if (out_valid_o && out_ready_i) got_q.push_back(out_result_o);
      end
   end

   task automatic tick();
      @(posedge clk_i); #1;
   endtask

   task automatic push_one(input logic [7:0] a, input logic [7:0] b);
      int t = 0;
      in_valid_i = 1'b1; in_a_i = a; in_b_i = b;
      while (!in_ready_o && t < 1000) begin tick(); t++; end
      if (t >= 1000) check("push_timeout", int'(in_ready_o), 1);
      tick();
      in_valid_i = 1'b0;
   endtask

   task automatic wait_results(input int n, input int budget);
      int t = 0;
      while (got_q.size() < n && t < budget) begin tick(); t++; end
      check("result_count", got_q.size(), n);
   endtask

   task automatic wait_valid(input int budget);
      int t = 0;
      while (!out_valid_o && t < budget) begin tick(); t++; end
   endtask

   initial begin
      int s0, d0, t;
      int r;
      vec[0]  = '{8'd10,  8'd49,  16'd70};
      vec[1]  = '{8'd255, 8'd255, 16'd3825};
      vec[2]  = '{8'd3,   8'd16,  16'd12};
      vec[3]  = '{8'd0,   8'd100, 16'd0};
      vec[4]  = '{8'd7,   8'd0,   16'd0};
      vec[5]  = '{8'd1,   8'd1,   16'd1};
      vec[6]  = '{8'd2,   8'd4,   16'd4};
      vec[7]  = '{8'd3,   8'd9,   16'd9};
      vec[8]  = '{8'd4,   8'd16,  16'd16};
      vec[9]  = '{8'd5,   8'd25,  16'd25};
      vec[10] = '{8'd2,   8'd9,   16'd6};
      vec[11] = '{8'd6,   8'd36,  16'd36};

      // Reset state
      repeat (3) @(posedge clk_i);
      #1;
      check("rst_in_ready", int'(in_ready_o), 0);
      check("rst_out_valid", int'(out_valid_o), 0);
      check("rst_result", int'(out_result_o), 0);
      check("rst_pending", int'(pending_o), 0);
      check("rst_err", int'(err_o), 0);
      check("rst_start", int'(sys_start_o), 0);
      check("rst_sys_ab", int'({sys_a_o, sys_b_o}), 0);
      rst_i = 1'b0;
      #1;
      check("post_rst_in_ready", int'(in_ready_o), 1);
      tick();

      // Single job
      s0 = start_cnt;
      push_one(vec[0].a, vec[0].b);
      wait_valid(100);
      check("single_valid", int'(out_valid_o), 1);
      check("single_result", int'(out_result_o), int'(vec[0].exp));
      check("single_starts", start_cnt - s0, 1);
      repeat (5) tick();
      check("single_hold_valid", int'(out_valid_o), 1);
      check("single_hold_result", int'(out_result_o), int'(vec[0].exp));
      out_ready_i = 1'b1;
      tick();
      check("single_drained", int'(out_valid_o), 0);
      check("single_stable_ab", stab_err, 0);
      got_q.delete();

      // Backpressure with two jobs queued
      out_ready_i = 1'b0;
      s0 = start_cnt;
      push_one(vec[0].a, vec[0].b);
      push_one(vec[10].a, vec[10].b);
      wait_valid(100);
      repeat (20) tick();
      check("bp_no_second_start", start_cnt - s0, 1);
      check("bp_held_result", int'(out_result_o), int'(vec[0].exp));
      check("bp_held_valid", int'(out_valid_o), 1);
      check("bp_pending", int'(pending_o), 1);
      out_ready_i = 1'b1;
      wait_results(2, 100);
      r = (got_q.size() > 0) ? int'(got_q[0]) : -1;
      check("bp_first", r, int'(vec[0].exp));
      r = (got_q.size() > 1) ? int'(got_q[1]) : -1;
      check("bp_second", r, int'(vec[10].exp));
      check("bp_starts", start_cnt - s0, 2);
      got_q.delete();

      // Back-to-back table jobs
      s0 = start_cnt;
      for (int i = 1; i <= 4; i++) push_one(vec[i].a, vec[i].b);
      wait_results(4, 400);
      for (int i = 1; i <= 4; i++) begin
         r = (got_q.size() > i - 1) ? int'(got_q[i-1]) : -1;
         check($sformatf("b2b_result_%0d", i), r, int'(vec[i].exp));
      end
      check("b2b_starts", start_cnt - s0, 4);
      check("b2b_spacing", spacing_err, 0);
      check("b2b_stable_ab", stab_err, 0);
      got_q.delete();

      // FIFO full with done withheld
      stall = 1'b1;
      d0 = done_cnt;
      for (int i = 5; i <= 8; i++) push_one(vec[i].a, vec[i].b);
      check("full_in_ready", int'(in_ready_o), 0);
      check("full_pending", int'(pending_o), 4);
      in_valid_i = 1'b1; in_a_i = vec[9].a; in_b_i = vec[9].b;
      repeat (10) tick();
      check("full_fifth_blocked", int'(pending_o), 4);
      stall = 1'b0;
      t = 0;
      while (!in_ready_o && t < 200) begin tick(); t++; end
      check("full_fifth_after_done", done_cnt - d0, 1);
      tick();
      in_valid_i = 1'b0;
      wait_results(5, 600);
      for (int i = 5; i <= 9; i++) begin
         r = (got_q.size() > i - 5) ? int'(got_q[i-5]) : -1;
         check($sformatf("full_result_%0d", i), r, int'(vec[i].exp));
      end
      check("full_no_err", int'(err_o), 0);
      got_q.delete();

      // Watchdog
      stall = 1'b1;
      push_one(vec[11].a, vec[11].b);
      t = 0;
      while (!sys_start_o && t < 50) begin tick(); t++; end
      check("wd_start_seen", int'(sys_start_o), 1);
      repeat (TIMEOUT) tick();
      check("wd_err_before", int'(err_o), 0);
      tick();
      check("wd_err_at_timeout", int'(err_o), 1);
      repeat (45) tick();
      check("wd_err_sticky", int'(err_o), 1);
      stall = 1'b0;
      wait_results(1, 100);
      r = (got_q.size() > 0) ? int'(got_q[0]) : -1;
      check("wd_late_result", r, int'(vec[11].exp));
      check("wd_err_after_done", int'(err_o), 1);
      check("wd_pending", int'(pending_o), 0);
      got_q.delete();

      // Reset in the middle of a job with three queued
      stall = 1'b1;
      for (int i = 1; i <= 3; i++) push_one(vec[i].a, vec[i].b);
      repeat (4) tick();
      check("mid_pending_before", int'(pending_o), 3);
      s0 = start_cnt;
      #2 rst_i = 1'b1;
      #1;
      check("mid_out_valid", int'(out_valid_o), 0);
      check("mid_pending", int'(pending_o), 0);
      check("mid_err", int'(err_o), 0);
      check("mid_in_ready", int'(in_ready_o), 0);
      check("mid_start", int'(sys_start_o), 0);
      check("mid_sys_ab", int'({sys_a_o, sys_b_o}), 0);
      tick();
      rst_i = 1'b0;
      stall = 1'b0;
      repeat (40) tick();
      check("mid_no_capture", got_q.size(), 0);
      check("mid_no_start", start_cnt - s0, 0);
      check("mid_out_valid_after", int'(out_valid_o), 0);
      check("mid_pending_after", int'(pending_o), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
